// File: rtl/mem_pkg.sv
// mem_pkg: shared memory geometry defaults and streamer FSM state encoding
package mem_pkg;
  localparam int MEM_ADDR_W = 17;
  localparam int MEM_DATA_W = 24;
  localparam int MEM_IMAGE_WORDS = 90000;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t READ = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t FINISH = 2'd3;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through buffer with occupancy count
// ports: push/push_data write side; pop/pop_data/valid read side (pop_data is 0 when empty); count = words held
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  // gating keeps the output at zero while empty, so no stale word survives a reset
  assign pop_data = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/image_streamer.sv
// image_streamer: streams a block of memory words out through a ready/valid FIFO
// ports: start/base_addr/length request; busy/done status; mem_* one-cycle-latency read port;
//        out_valid/out_ready/out_data/out_last stream with last-word marker
module image_streamer import mem_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int IMAGE_WORDS = MEM_IMAGE_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_next;
  logic [ADDR_W-1:0] remaining, eff_len;
  logic in_flight, flight_last, issue;
  logic [CW-1:0] fifo_count;
  logic [DATA_W:0] fifo_data;
  assign eff_len = length > ADDR_W'(IMAGE_WORDS) ? ADDR_W'(IMAGE_WORDS) : length;
  // the in-flight word already owns a FIFO slot, so reads never overflow the buffer
  assign issue = state == READ && remaining != '0 &&
                 (CW+1)'(fifo_count) + (CW+1)'(in_flight) < (CW+1)'(FIFO_DEPTH);
  assign mem_read_enable = issue;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign out_data = fifo_data[DATA_W-1:0];
  assign out_last = fifo_data[DATA_W];
  always_comb
    state_next = state == IDLE  ? (start ? (eff_len == '0 ? FINISH : READ) : IDLE) :
                 state == READ  ? (issue && remaining == ADDR_W'(1) ? DRAIN : READ) :
                 state == DRAIN ? (fifo_count == '0 && !in_flight ? FINISH : DRAIN) :
                 IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      mem_address <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      flight_last <= 1'b0;
    end else begin
      state <= state_next;
      in_flight <= issue;
      flight_last <= issue && remaining == ADDR_W'(1);
      if (state == IDLE && start) begin
        mem_address <= base_addr;
        remaining <= eff_len;
      end else if (issue) begin
        mem_address <= mem_address == ADDR_W'(IMAGE_WORDS - 1) ? '0 : mem_address + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
    end
  // the last flag travels with its word so it survives any backpressure pattern
  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W + 1)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(in_flight),
    .push_data({flight_last, mem_read_data}),
    .pop(out_ready),
    .pop_data(fifo_data),
    .valid(out_valid),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_image_streamer.sv
// tb_image_streamer: directed self-checking bench for image_streamer
module tb_image_streamer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [16:0] base_addr = '0, length = '0, mem_address;
  logic [23:0] mem_read_data = '0, out_data;
  logic busy, done, mem_read_enable, out_valid, out_last;
  int passed = 0, total = 0, fails = 0;
  int got_d[$], got_l[$], acc_cyc[$], iss_a[$];
  int done_cnt, done_cyc, viol, busy0, timeout, issued, accepted;

  image_streamer dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_read_enable(mem_read_enable), .mem_address(mem_address),
    .mem_read_data(mem_read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) mem_read_data <= mem_read_enable ? {7'b0, mem_address} : 24'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    check({tag, "_count"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], (base + i) % 90000);
      check($sformatf("%s_last%0d", tag, i), got_l[i], i == n - 1);
    end
  endtask

  task automatic run_xfer(input int base, input int len, input int pct, input int restart_cyc, input int abort_n);
    int cyc, post;
    got_d.delete(); got_l.delete(); acc_cyc.delete(); iss_a.delete();
    done_cnt = 0; done_cyc = -1; viol = 0; issued = 0; accepted = 0; busy0 = 0;
    start = 1'b1; base_addr = 17'(base); length = 17'(len); out_ready = 1'b1;
    @(posedge clock); #1;
    cyc = 0; post = -1;
    while (cyc < 400 && post < 3 && !(abort_n > 0 && accepted >= abort_n)) begin
      if (cyc == restart_cyc) begin start = 1'b1; base_addr = 17'd500; length = 17'd2; end
      else start = 1'b0;
      out_ready = $urandom_range(99) < pct;
      if (cyc == 0) busy0 = busy;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (mem_read_enable) begin
        if (issued - accepted >= 4) viol++;
        iss_a.push_back(int'(mem_address));
        issued++;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data)); got_l.push_back(int'(out_last));
        acc_cyc.push_back(cyc); accepted++;
      end
      if (post >= 0) post++; else if (done) post = 0;
      @(posedge clock); #1; cyc++;
    end
    start = 1'b0;
    timeout = cyc >= 400;
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_en", mem_read_enable, 0);
    check("rst_addr", mem_address, 0); check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0); check("rst_last", out_last, 0);
    @(posedge clock); @(posedge clock); #1; reset = 1'b0;

    run_xfer(0, 8, 100, -1, 0);
    check("t1_timeout", timeout, 0); check("t1_busy0", busy0, 1);
    check_words("t1", 0, 8);
    check("t1_done_cnt", done_cnt, 1); check("t1_done_cyc", done_cyc, 11);
    check("t1_first_cyc", acc_cyc.size() > 0 ? acc_cyc[0] : -1, 2);
    check("t1_last_cyc", acc_cyc.size() > 7 ? acc_cyc[7] : -1, 9);
    check("t1_busy_after", busy, 0);

    run_xfer(89998, 4, 100, -1, 0);
    check("t2_timeout", timeout, 0);
    check_words("t2", 89998, 4);
    check("t2_wrap_addr", iss_a.size() > 2 ? iss_a[2] : -1, 0);
    check("t2_done_cnt", done_cnt, 1);

    run_xfer(300, 16, 50, -1, 0);
    check("t3_timeout", timeout, 0);
    check_words("t3", 300, 16);
    check("t3_overissue", viol, 0); check("t3_done_cnt", done_cnt, 1);

    run_xfer(77, 0, 100, -1, 0);
    check("t4_timeout", timeout, 0); check("t4_reads", issued, 0);
    check("t4_words", got_d.size(), 0); check("t4_done_cyc", done_cyc, 0);
    check("t4_done_cnt", done_cnt, 1);

    run_xfer(200, 6, 100, 3, 0);
    check("t5_timeout", timeout, 0);
    check_words("t5", 200, 6);
    check("t5_done_cnt", done_cnt, 1);

    run_xfer(40, 10, 100, -1, 3);
    check("t6_delivered", accepted, 3); check("t6_no_done", done_cnt, 0);
    reset = 1'b1; #1;
    check("t6_busy", busy, 0); check("t6_done", done, 0); check("t6_en", mem_read_enable, 0);
    check("t6_addr", mem_address, 0); check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0); check("t6_last", out_last, 0);
    @(posedge clock); @(posedge clock); #1; reset = 1'b0;
    run_xfer(100, 2, 100, -1, 0);
    check("t7_timeout", timeout, 0); check("t7_busy0", busy0, 1);
    check_words("t7", 100, 2);
    check("t7_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
